// File: rtl/btn_pkg.sv
// Shared types and timing defaults for the push-button press classifier.
// The defaults assume the 50 MHz processor clock.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD      = 2'd1,
        LONG_WAIT = 2'd2
    } btn_state_t;

    localparam int DEBOUNCE_10MS_50MHZ = 500_000;
    localparam int LONG_800MS_50MHZ    = 40_000_000;
    localparam int MIN_SYNC_STAGES     = 2;

    // Width of a counter that must be able to hold the value max_count.
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronises the raw button pin and accepts a level change only after it has
// been stable for DEBOUNCE_CYCLES samples; the output is normalised to 1 = pressed.
module button_debouncer
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
    parameter bit ACTIVE_LOW_BTN  = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic pressed
);

    // Fewer than two stages would leave the pin metastability-exposed.
    localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
    localparam int CNT_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STAGES-1:0] RELEASED_RAW = {STAGES{ACTIVE_LOW_BTN}};

    logic [STAGES-1:0] sync_reg;
    logic [STAGES-1:0] sync_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic              pressed_reg;
    logic              level;

    assign sync_next[0] = btn_raw;
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_sync
        assign sync_next[gi] = sync_reg[gi-1];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_reg <= RELEASED_RAW;
        end else begin
            sync_reg <= sync_next;
        end
    end

    assign level = sync_reg[STAGES-1] ^ ACTIVE_LOW_BTN;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_reg     <= '0;
            pressed_reg <= 1'b0;
        end else if (level == pressed_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            pressed_reg <= ~pressed_reg;
            cnt_reg     <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign pressed = pressed_reg;

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced presses of one button as short or long and keeps a
// sticky flag for each class until the CPU acknowledges it.
module button_press_classifier
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
    parameter int LONG_CYCLES     = LONG_800MS_50MHZ,
    parameter bit ACTIVE_LOW_BTN  = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    input  logic short_ack,
    input  logic long_ack,
    output logic short_flag,
    output logic long_flag,
    output logic pressed
);

    localparam int HOLD_W = cnt_width(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_FIRST = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(LONG_CYCLES);

    logic              pressed_db;
    btn_state_t        state_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic              short_flag_reg;
    logic              long_flag_reg;

    button_debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW_BTN  (ACTIVE_LOW_BTN)
    ) u_debouncer (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (btn_raw),
        .pressed (pressed_db)
    );

    // Acks are applied first so that a set in the same cycle overrides them.
    // The cycle that enters HOLD already counts as the first held cycle, which
    // makes a hold of exactly LONG_CYCLES debounced cycles classify as long.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            hold_cnt_reg   <= '0;
            short_flag_reg <= 1'b0;
            long_flag_reg  <= 1'b0;
        end else begin
            if (short_ack) short_flag_reg <= 1'b0;
            if (long_ack)  long_flag_reg  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    hold_cnt_reg <= '0;
                    if (pressed_db) begin
                        state_reg    <= HOLD;
                        hold_cnt_reg <= HOLD_FIRST;
                    end
                end
                HOLD: begin
                    if (!pressed_db) begin
                        short_flag_reg <= 1'b1;
                        state_reg      <= IDLE;
                        hold_cnt_reg   <= '0;
                    end else if (hold_cnt_reg == HOLD_LAST) begin
                        long_flag_reg <= 1'b1;
                        state_reg     <= LONG_WAIT;
                        hold_cnt_reg  <= HOLD_MAX;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                LONG_WAIT: begin
                    hold_cnt_reg <= HOLD_MAX;
                    if (!pressed_db) begin
                        state_reg    <= IDLE;
                        hold_cnt_reg <= '0;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    hold_cnt_reg <= '0;
                end
            endcase
        end
    end

    assign short_flag = short_flag_reg;
    assign long_flag  = long_flag_reg;
    assign pressed    = pressed_db;

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with a cycle-stamped scoreboard of
// expected output transitions (SYNC=2, DEBOUNCE=4, LONG=20, active-high pin).
module tb_button_press_classifier;

    logic clock = 1'b0;
    logic reset;
    logic btn_raw;
    logic short_ack;
    logic long_ack;
    logic short_flag;
    logic long_flag;
    logic pressed;

    button_press_classifier #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .ACTIVE_LOW_BTN  (1'b0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .short_ack  (short_ack),
        .long_ack   (long_ack),
        .short_flag (short_flag),
        .long_flag  (long_flag),
        .pressed    (pressed)
    );

    always #5 clock = ~clock;

    // Signal codes: 0 = pressed, 1 = short_flag, 2 = long_flag.
    localparam int SIG_P = 0;
    localparam int SIG_S = 1;
    localparam int SIG_L = 2;
    localparam int LAT   = 6;   // sync stages + debounce cycles
    localparam int LONG  = 20;

    typedef struct {
        int   sig;
        logic val;
        int   cyc;
    } ev_t;

    ev_t        exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    logic [2:0] prev  = 3'b000;

    function automatic string sig_name(input int s);
        case (s)
            SIG_P:   return "pressed";
            SIG_S:   return "short_flag";
            SIG_L:   return "long_flag";
            default: return "none";
        endcase
    endfunction

    // Keeps the queue ordered by cycle, then by signal code.
    function automatic void expect_ev(input int sig, input logic val, input int at);
        ev_t e;
        int  i;
        e.sig = sig;
        e.val = val;
        e.cyc = at;
        i = 0;
        while (i < exp_q.size() &&
               (exp_q[i].cyc < at || (exp_q[i].cyc == at && exp_q[i].sig < sig))) i++;
        exp_q.insert(i, e);
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp_val);
        tests++;
        assert (obs === exp_val) else begin
            fails++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp_val);
        end
    endtask

    task automatic check_ev(input string tag, input int osig, input logic oval, input int ocyc,
                            input int esig, input logic exp_val, input int ecyc);
        tests++;
        assert (osig == esig && oval === exp_val && ocyc == ecyc) else begin
            fails++;
            $error("FAIL %s: observed %s=%b at cycle %0d, expected %s=%b at cycle %0d",
                   tag, sig_name(osig), oval, ocyc, sig_name(esig), exp_val, ecyc);
        end
    endtask

    // Advance one cycle and pop/compare every output transition the DUT made.
    task automatic tick();
        logic [2:0] cur;
        ev_t        e;
        @(negedge clock);
        cyc++;
        cur = {long_flag, short_flag, pressed};
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check_ev("missed event", -1, 1'b0, cyc, e.sig, e.val, e.cyc);
        end
        for (int s = 0; s < 3; s++) begin
            if (cur[s] !== prev[s]) begin
                if (exp_q.size() == 0) begin
                    check_ev("unexpected change", s, cur[s], cyc, -1, 1'b0, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_ev("transition", s, cur[s], cyc, e.sig, e.val, e.cyc);
                    $display("[TB] cycle %0d: %s -> %b", cyc, sig_name(s), cur[s]);
                end
            end
        end
        prev = cur;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input int n, input string what);
        $display("[TB] %s: btn_raw high for %0d cycles from cycle %0d", what, n, cyc);
        btn_raw = 1'b1;
        repeat (n) tick();
        btn_raw = 1'b0;
    endtask

    task automatic pulse_ack(input logic s, input logic l);
        $display("[TB] ack short=%b long=%b at cycle %0d", s, l, cyc);
        short_ack = s;
        long_ack  = l;
        tick();
        short_ack = 1'b0;
        long_ack  = 1'b0;
    endtask

    initial begin
        int c;
        reset     = 1'b1;
        btn_raw   = 1'b1;
        short_ack = 1'b0;
        long_ack  = 1'b0;
        #1 reset  = 1'b0;

        // Reset held with the button down; outputs must stay cleared.
        repeat (10) begin
            tick();
            check_bit("reset pressed", pressed, 1'b0);
            check_bit("reset short_flag", short_flag, 1'b0);
            check_bit("reset long_flag", long_flag, 1'b0);
        end
        #2 reset = 1'b1;
        c = cyc;
        $display("[TB] reset released at cycle %0d with button held", c);
        expect_ev(SIG_P, 1'b1, c + LAT);
        expect_ev(SIG_L, 1'b1, c + LAT + LONG);
        idle(30);
        btn_raw = 1'b0;
        expect_ev(SIG_P, 1'b0, cyc + LAT);
        idle(12);
        check_bit("post-reset long_flag", long_flag, 1'b1);
        check_bit("post-reset short_flag", short_flag, 1'b0);
        expect_ev(SIG_L, 1'b0, cyc + 1);
        pulse_ack(1'b0, 1'b1);
        idle(5);

        // Three-cycle glitch is rejected.
        press(3, "glitch");
        idle(30);
        check_bit("glitch pressed", pressed, 1'b0);
        check_bit("glitch short_flag", short_flag, 1'b0);
        check_bit("glitch long_flag", long_flag, 1'b0);

        // Four-cycle pulse is the shortest accepted press.
        c = cyc;
        expect_ev(SIG_P, 1'b1, c + LAT);
        expect_ev(SIG_P, 1'b0, c + 4 + LAT);
        expect_ev(SIG_S, 1'b1, c + 4 + LAT + 1);
        press(4, "minimum press");
        idle(20);
        check_bit("min press short_flag", short_flag, 1'b1);
        expect_ev(SIG_S, 1'b0, cyc + 1);
        pulse_ack(1'b1, 1'b0);
        idle(3);
        check_bit("short_ack clears", short_flag, 1'b0);

        // Ordinary short press.
        c = cyc;
        expect_ev(SIG_P, 1'b1, c + LAT);
        expect_ev(SIG_P, 1'b0, c + 10 + LAT);
        expect_ev(SIG_S, 1'b1, c + 10 + LAT + 1);
        press(10, "short press");
        idle(15);
        check_bit("short press long_flag", long_flag, 1'b0);
        pulse_ack(1'b0, 1'b1);
        idle(2);
        check_bit("long_ack keeps short_flag", short_flag, 1'b1);
        check_bit("long_ack on clear long_flag", long_flag, 1'b0);

        // 19 debounced cycles: still short; collapses into the pending flag.
        c = cyc;
        expect_ev(SIG_P, 1'b1, c + LAT);
        expect_ev(SIG_P, 1'b0, c + 19 + LAT);
        press(19, "19-cycle press, flag pending");
        idle(15);
        check_bit("19 cycles short_flag", short_flag, 1'b1);
        check_bit("19 cycles long_flag", long_flag, 1'b0);
        expect_ev(SIG_S, 1'b0, cyc + 1);
        pulse_ack(1'b1, 1'b0);
        idle(3);

        // 20 debounced cycles: long, with no short on release.
        c = cyc;
        expect_ev(SIG_P, 1'b1, c + LAT);
        expect_ev(SIG_P, 1'b0, c + 20 + LAT);
        expect_ev(SIG_L, 1'b1, c + LAT + LONG);
        press(20, "20-cycle press");
        idle(15);
        check_bit("20 cycles short_flag", short_flag, 1'b0);
        check_bit("20 cycles long_flag", long_flag, 1'b1);
        pulse_ack(1'b1, 1'b0);
        idle(2);
        check_bit("short_ack on clear short_flag", short_flag, 1'b0);
        check_bit("short_ack keeps long_flag", long_flag, 1'b1);

        // New long press whose set edge coincides with long_ack: set wins.
        c = cyc;
        expect_ev(SIG_P, 1'b1, c + LAT);
        expect_ev(SIG_P, 1'b0, c + 30 + LAT);
        $display("[TB] long press with coincident long_ack from cycle %0d", c);
        btn_raw = 1'b1;
        idle(LAT + LONG - 1);
        long_ack = 1'b1;
        tick();
        long_ack = 1'b0;
        check_bit("set beats ack long_flag", long_flag, 1'b1);
        idle(4);
        btn_raw = 1'b0;
        idle(15);
        check_bit("long hold short_flag", short_flag, 1'b0);
        expect_ev(SIG_L, 1'b0, cyc + 1);
        pulse_ack(1'b0, 1'b1);
        idle(2);
        pulse_ack(1'b0, 1'b1);
        idle(2);
        check_bit("long_ack on clear long_flag", long_flag, 1'b0);

        // Asynchronous reset in the middle of a hold.
        c = cyc;
        expect_ev(SIG_P, 1'b1, c + LAT);
        $display("[TB] hold then mid-hold reset from cycle %0d", c);
        btn_raw = 1'b1;
        idle(10);
        #2 reset = 1'b0;
        #1;
        check_bit("async reset pressed", pressed, 1'b0);
        check_bit("async reset short_flag", short_flag, 1'b0);
        check_bit("async reset long_flag", long_flag, 1'b0);
        expect_ev(SIG_P, 1'b0, cyc + 1);
        tick();
        #2 reset = 1'b1;
        c = cyc;
        expect_ev(SIG_P, 1'b1, c + LAT);
        expect_ev(SIG_L, 1'b1, c + LAT + LONG);
        idle(30);
        btn_raw = 1'b0;
        expect_ev(SIG_P, 1'b0, cyc + LAT);
        idle(12);
        check_bit("after reset long_flag", long_flag, 1'b1);
        check_bit("after reset short_flag", short_flag, 1'b0);
        expect_ev(SIG_L, 1'b0, cyc + 1);
        pulse_ack(1'b0, 1'b1);
        idle(5);

        check_bit("scoreboard drained", exp_q.size() == 0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/button_press_classifier.md
Name: button_press_classifier

Overview:
- Producer side of the memory-mapped button interface: turns one raw push-button pin into sticky short-press and long-press flags.
- Flags feed the processor's button read slots; the wrapper pulses an acknowledge when the CPU reads a slot.
- One instance per physical button, clocked by the 50 MHz processor clock.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on the raw pin (minimum 2).
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples needed to accept a level change (10 ms at 50 MHz).
- LONG_CYCLES, 40000000, debounced hold length that classifies a press as long (0.8 s at 50 MHz); must be greater than DEBOUNCE_CYCLES.
- ACTIVE_LOW_BTN, 0, 1 means the raw pin reads 0 when pressed.

Ports:
- clock, in, 1, 50 MHz system clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-low reset (0 = reset asserted).
- btn_raw, in, 1, asynchronous button pin.
- short_ack, in, 1, one-cycle pulse; clears short_flag.
- long_ack, in, 1, one-cycle pulse; clears long_flag.
- short_flag, out, 1, sticky: a short press has completed.
- long_flag, out, 1, sticky: a long press has been reached.
- pressed, out, 1, debounced button level, with polarity normalised so 1 = pressed.

Behaviour:
- Reset (reset=0, asynchronous):
  - All synchroniser flops, the debounce counter, the hold counter and the FSM are cleared; FSM goes to IDLE.
  - short_flag=0, long_flag=0, pressed=0.
  - Synchroniser flops reset to the "released" level.
- Synchroniser: SYNC_STAGES flops; the level is inverted after the last stage when ACTIVE_LOW_BTN=1.
- Debounce:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - While the synchronised level equals pressed, the counter is held at 0.
  - While it differs, the counter increments each cycle. When it reaches DEBOUNCE_CYCLES-1 and the level still differs, pressed toggles on the next edge and the counter clears.
  - Any sample equal to pressed before that point clears the counter; glitches shorter than DEBOUNCE_CYCLES are ignored.
  - Latency: a clean raw edge appears on pressed exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles later.
- FSM (driven by pressed; hold counter has $clog2(LONG_CYCLES+1) bits and saturates at LONG_CYCLES):
  - IDLE: hold counter = 0. pressed rising -> HOLD.
  - HOLD: hold counter increments each cycle. When it reaches LONG_CYCLES-1 while still pressed -> long_flag set next edge, go to LONG_WAIT. pressed falling first -> short_flag set next edge, go to IDLE.
  - LONG_WAIT: stays until pressed falls -> IDLE. No short_flag is produced for a long press.
- Classification boundary: a hold of exactly LONG_CYCLES debounced cycles is long; LONG_CYCLES-1 cycles is short.
- Flags:
  - Each flag stays 1 until its own ack pulse.
  - An ack while the flag is 0 has no effect.
  - If set and ack happen in the same cycle, set wins; the flag stays 1, so a new event is not lost.
  - Repeated events before an ack collapse into a single flag; there is no count.
  - short_ack does not affect long_flag, and long_ack does not affect short_flag.
- Reset mid-press: all state is lost immediately. After release of reset with the button still held, the next debounce accepts it as a fresh press.
- All outputs are registered; nothing is combinational from inputs to outputs.

Decomposition:
- Shared package btn_pkg:
  - FSM state enum: IDLE=2'd0, HOLD=2'd1, LONG_WAIT=2'd2.
  - Default timing constants DEBOUNCE_10MS_50MHZ and LONG_800MS_50MHZ.
- Sub-module button_debouncer contains the synchroniser and debounce counter (parameters SYNC_STAGES, DEBOUNCE_CYCLES, ACTIVE_LOW_BTN; output pressed).
- The classifier FSM and flag logic stay in the top module.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW_BTN=0):
- Reset check: hold reset=0 with btn_raw=1 for 10 cycles, then release reset. Required: all outputs 0 throughout reset; pressed rises exactly 6 cycles after reset release.
- Glitch rejection: btn_raw=1 for 3 cycles, then 0. Required: pressed, short_flag and long_flag stay 0 for the next 30 cycles.
- Short press: btn_raw=1 for 10 cycles, then 0. Required: pressed rises 6 cycles after press and falls 6 cycles after release; short_flag rises 1 cycle after pressed falls; long_flag stays 0.
- Short/long boundary:
  - Hold with exactly 19 debounced pressed cycles -> short_flag only.
  - Hold with 20 or more -> long_flag rises while still held, and no short_flag on release.
- Acknowledge behaviour:
  - Pulse short_ack -> short_flag=0 next cycle.
  - Pulse long_ack on the same edge that a new long press sets long_flag -> long_flag remains 1.
  - Ack while the flag is 0 -> flag stays 0.
- Asynchronous reset mid-hold: assert reset=0 for 1 cycle after 10 held cycles. Required: all outputs 0 immediately; with btn_raw still 1, pressed re-rises 6 cycles after release of reset, and long_flag is set 20 cycles after that.
